// File: rtl/baud_ctrl.sv
// baud_ctrl: shadow divisor/mode registers, commit sequencing through a
// validate / wait-for-idle / held-reload flow, and a bclk period monitor
// reporting lock and errors via a status register.
module baud_ctrl #(
   parameter int unsigned HOLD_CYC    = 2,
   parameter logic [15:0] DEFAULT_DIV = 16'h00A0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   input  logic        line_busy,
   input  logic        bclk,
   output logic [15:0] dlh_dll,
   output logic        mode_osl,
   output logic        bgen_rstn,
   output logic        baud_ok
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_WAIT  = 3'd2,
      ST_APPLY = 3'd3,
      ST_SYNC  = 3'd4,
      ST_RUN   = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] shadow_div_q, shadow_div_d;
   logic        shadow_mode_q, shadow_mode_d;
   logic [15:0] pend_div_q, pend_div_d;
   logic        pend_mode_q, pend_mode_d;
   logic [15:0] pend_quot_q, pend_quot_d;
   logic [15:0] act_quot_q, act_quot_d;
   logic [15:0] dlh_dll_q, dlh_dll_d;
   logic        mode_osl_q, mode_osl_d;
   logic        bgen_rstn_q, bgen_rstn_d;
   logic        baud_ok_q, baud_ok_d;
   logic        cfg_err_q, cfg_err_d;
   logic        tick_err_q, tick_err_d;
   logic        applied_q, applied_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic [15:0] mon_cnt_q, mon_cnt_d;
   logic [7:0]  rdata_q, rdata_d;

   logic        commit, w1c, cfg_valid, load_active, tick_good, tick_bad;
   logic [15:0] quot;
   logic [7:0]  status;

   assign commit    = wr_en && (addr == 2'd2) && wdata[1];
   assign w1c       = wr_en && (addr == 2'd3);
   assign quot      = shadow_mode_q ? (shadow_div_q / 16'd13) : {4'b0000, shadow_div_q[15:4]};
   assign cfg_valid = (quot != '0);
   assign status    = {1'b0, state_q, !(state_q inside {ST_RUN, ST_IDLE}),
                       tick_err_q, cfg_err_q, baud_ok_q};

   // Period monitor verdicts; only meaningful while the generator is released
   assign tick_good = bgen_rstn_q && bclk && (mon_cnt_q == act_quot_q);
   assign tick_bad  = bgen_rstn_q && ((bclk && (mon_cnt_q != act_quot_q)) ||
                                      (!bclk && (mon_cnt_q > act_quot_q)));

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         shadow_div_q  <= DEFAULT_DIV;
         shadow_mode_q <= 1'b0;
         pend_div_q    <= DEFAULT_DIV;
         pend_mode_q   <= 1'b0;
         pend_quot_q   <= '0;
         act_quot_q    <= '0;
         dlh_dll_q     <= DEFAULT_DIV;
         mode_osl_q    <= 1'b0;
         bgen_rstn_q   <= 1'b0;
         baud_ok_q     <= 1'b0;
         cfg_err_q     <= 1'b0;
         tick_err_q    <= 1'b0;
         applied_q     <= 1'b0;
         hold_cnt_q    <= '0;
         mon_cnt_q     <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         shadow_div_q  <= shadow_div_d;
         shadow_mode_q <= shadow_mode_d;
         pend_div_q    <= pend_div_d;
         pend_mode_q   <= pend_mode_d;
         pend_quot_q   <= pend_quot_d;
         act_quot_q    <= act_quot_d;
         dlh_dll_q     <= dlh_dll_d;
         mode_osl_q    <= mode_osl_d;
         bgen_rstn_q   <= bgen_rstn_d;
         baud_ok_q     <= baud_ok_d;
         cfg_err_q     <= cfg_err_d;
         tick_err_q    <= tick_err_d;
         applied_q     <= applied_d;
         hold_cnt_q    <= hold_cnt_d;
         mon_cnt_q     <= mon_cnt_d;
         rdata_q       <= rdata_d;
      end
   end

   // Next-state logic; a commit in any non-IDLE state restarts validation
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (commit) state_d = ST_CHECK;
         ST_CHECK: begin
            if (commit)          state_d = ST_CHECK;
            else if (!cfg_valid) state_d = applied_q ? ST_RUN : ST_IDLE;
            else if (line_busy)  state_d = ST_WAIT;
            else                 state_d = ST_APPLY;
         end
         ST_WAIT:  begin
            if (commit)          state_d = ST_CHECK;
            else if (!line_busy) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            if (commit)          state_d = ST_CHECK;
            else if (hold_cnt_q == 4'(HOLD_CYC - 32'd1)) state_d = ST_SYNC;
         end
         ST_SYNC:  begin
            if (commit)          state_d = ST_CHECK;
            else if (bclk)       state_d = ST_RUN;
         end
         ST_RUN:   if (commit) state_d = ST_CHECK;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Registered-output and datapath next values
   always_comb begin
      shadow_div_d  = shadow_div_q;
      shadow_mode_d = shadow_mode_q;
      pend_div_d    = pend_div_q;
      pend_mode_d   = pend_mode_q;
      pend_quot_d   = pend_quot_q;
      act_quot_d    = act_quot_q;
      dlh_dll_d     = dlh_dll_q;
      mode_osl_d    = mode_osl_q;
      bgen_rstn_d   = bgen_rstn_q;
      baud_ok_d     = baud_ok_q;
      cfg_err_d     = cfg_err_q;
      tick_err_d    = tick_err_q;
      applied_d     = applied_q;
      hold_cnt_d    = '0;
      mon_cnt_d     = '0;
      rdata_d       = rdata_q;

      if (wr_en) begin
         unique case (addr)
            2'd0:    shadow_div_d[7:0]  = wdata;
            2'd1:    shadow_div_d[15:8] = wdata;
            2'd2:    shadow_mode_d      = wdata[0];
            default: ;
         endcase
      end

      // Settings are frozen when validation passes, so later shadow writes
      // without a fresh commit cannot leak into the reload after WAIT.
      if (state_q == ST_CHECK) begin
         pend_div_d  = shadow_div_q;
         pend_mode_d = shadow_mode_q;
         pend_quot_d = quot;
      end

      load_active = (state_d == ST_APPLY) && (state_q != ST_APPLY);
      if (load_active) begin
         applied_d  = 1'b1;
         dlh_dll_d  = (state_q == ST_CHECK) ? shadow_div_q  : pend_div_q;
         mode_osl_d = (state_q == ST_CHECK) ? shadow_mode_q : pend_mode_q;
         act_quot_d = (state_q == ST_CHECK) ? quot          : pend_quot_q;
      end

      if (state_q == ST_APPLY) hold_cnt_d = hold_cnt_q + 4'd1;

      // CHECK/WAIT keep the current release level so an old generator keeps running
      unique case (state_d)
         ST_IDLE, ST_APPLY: bgen_rstn_d = 1'b0;
         ST_SYNC, ST_RUN:   bgen_rstn_d = 1'b1;
         default:           bgen_rstn_d = bgen_rstn_q;
      endcase

      if (bgen_rstn_q && !bclk)
         mon_cnt_d = (mon_cnt_q > act_quot_q) ? mon_cnt_q : mon_cnt_q + 16'd1;

      if (state_d inside {ST_IDLE, ST_APPLY})                     baud_ok_d = 1'b0;
      else if (tick_bad)                                          baud_ok_d = 1'b0;
      else if (tick_good && (state_q inside {ST_SYNC, ST_RUN}))   baud_ok_d = 1'b1;

      if (w1c && wdata[1]) cfg_err_d = 1'b0;
      if ((state_q == ST_CHECK) && !commit && !cfg_valid) cfg_err_d = 1'b1;

      if (w1c && wdata[2]) tick_err_d = 1'b0;
      if (tick_bad)        tick_err_d = 1'b1;

      if (rd_en) begin
         unique case (addr)
            2'd0:    rdata_d = shadow_div_q[7:0];
            2'd1:    rdata_d = shadow_div_q[15:8];
            2'd2:    rdata_d = {7'b0000000, shadow_mode_q};
            default: rdata_d = status;
         endcase
      end
   end

   assign rdata     = rdata_q;
   assign dlh_dll   = dlh_dll_q;
   assign mode_osl  = mode_osl_q;
   assign bgen_rstn = bgen_rstn_q;
   assign baud_ok   = baud_ok_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl with a behavioural baud generator that can be
// overridden cycle by cycle to inject early, late and missing ticks.
module tb_baud_ctrl;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en, line_busy;
   logic [1:0]  addr;
   logic [7:0]  wdata, rdata;
   logic        bclk = 1'b0;
   logic [15:0] dlh_dll;
   logic        mode_osl, bgen_rstn, baud_ok;

   int          n_checks = 0;
   int          n_errors = 0;

   logic        gen_manual = 1'b0;
   logic        man_bclk   = 1'b0;
   logic [15:0] gcnt = '0;
   logic [15:0] gq;

   baud_ctrl #(.HOLD_CYC(2), .DEFAULT_DIV(16'h00A0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .line_busy(line_busy), .bclk(bclk),
      .dlh_dll(dlh_dll), .mode_osl(mode_osl), .bgen_rstn(bgen_rstn),
      .baud_ok(baud_ok)
   );

   always #5 clk = ~clk;

   // Generator model: first tick Q cycles after release, then every Q+1
   always @(negedge clk) begin
      gq = mode_osl ? (dlh_dll / 16'd13) : (dlh_dll >> 4);
      if (!bgen_rstn) begin
         gcnt = '0;
         bclk = 1'b0;
      end else if (gen_manual) begin
         bclk = man_bclk;
         gcnt = man_bclk ? 16'd0 : gcnt + 16'd1;
      end else if (gcnt == gq) begin
         bclk = 1'b1;
         gcnt = '0;
      end else begin
         bclk = 1'b0;
         gcnt = gcnt + 16'd1;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      addr = a; rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
      d = rdata;
   endtask

   // Cycles from the current cycle (offset 0) to the next bclk cycle; -1 on timeout
   task automatic wait_bclk(output int n);
      int  off;
      bit  seen;
      off  = clk ? 0 : 1;
      seen = 1'b0;
      n    = -1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk); #1;
         if (bclk) begin seen = 1'b1; n = off; end
         else off++;
      end
   endtask

   task automatic man_tick(input int idle);
      for (int i = 0; i < idle; i++) begin
         man_bclk = 1'b0;
         step(1);
      end
      man_bclk = 1'b1;
      step(1);
      man_bclk = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      int n, falls, lows;
      logic prev;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; line_busy = 1'b0;
      step(3);
      rst = 1'b0;
      check("rst_div", dlh_dll, 16'h00A0);
      check("rst_mode", mode_osl, 0);
      check("rst_rstn", bgen_rstn, 0);
      check("rst_ok", baud_ok, 0);
      check("rst_rdata", rdata, 0);
      rd_reg(2'd3, v); check("rst_status", v, 8'h00);
      rd_reg(2'd0, v); check("rst_dll", v, 8'hA0);

      // Invalid commit before anything was applied stays in IDLE
      wr_reg(2'd0, 8'h05); wr_reg(2'd2, 8'h02); step(1);
      rd_reg(2'd3, v); check("idle_cfgerr_status", v, 8'h02);
      check("idle_cfgerr_rstn", bgen_rstn, 0);
      wr_reg(2'd3, 8'h02);

      // Basic commit, Q = 10
      wr_reg(2'd0, 8'hA0); wr_reg(2'd1, 8'h00); wr_reg(2'd2, 8'h02);
      check("t1_check_rstn", bgen_rstn, 0);
      step(1); check("t1_apply_div", dlh_dll, 16'h00A0); check("t1_apply0_rstn", bgen_rstn, 0);
      step(1); check("t1_apply1_rstn", bgen_rstn, 0);
      step(1); check("t1_release", bgen_rstn, 1);
      wait_bclk(n); check("t1_first_tick", n, 10);
      check("t1_ok_at_tick", baud_ok, 0);
      step(1); check("t1_ok_after", baud_ok, 1);
      rd_reg(2'd3, v); check("t1_status", v, 8'h51);

      // Invalid configurations while running
      wr_reg(2'd0, 8'h0F); wr_reg(2'd2, 8'h02); step(1);
      rd_reg(2'd3, v); check("t2a_status", v, 8'h53);
      check("t2a_div", dlh_dll, 16'h00A0); check("t2a_rstn", bgen_rstn, 1);
      wr_reg(2'd3, 8'h02);
      rd_reg(2'd3, v); check("t2a_cleared", v, 8'h51);
      wr_reg(2'd0, 8'h0C); wr_reg(2'd2, 8'h03); step(1);
      rd_reg(2'd3, v); check("t2b_status", v, 8'h53);
      check("t2b_div", dlh_dll, 16'h00A0); check("t2b_mode", mode_osl, 0);
      wr_reg(2'd3, 8'h02);
      rd_reg(2'd2, v); check("t2_ctrl_read", v, 8'h01);

      // Reload to Q = 20 deferred by a busy line
      line_busy = 1'b1;
      wr_reg(2'd0, 8'h04); wr_reg(2'd1, 8'h01); wr_reg(2'd2, 8'h03);
      n = 0;
      repeat (44) begin @(negedge clk); #1; if (bclk) n++; end
      step(1);
      check("t3_old_ticks", n, 4);
      check("t3_wait_ok", baud_ok, 1); check("t3_wait_div", dlh_dll, 16'h00A0);
      rd_reg(2'd3, v); check("t3_wait_status", v, 8'h29);
      line_busy = 1'b0;
      step(1); check("t3_apply_rstn", bgen_rstn, 0);
      check("t3_apply_div", dlh_dll, 16'h0104); check("t3_apply_mode", mode_osl, 1);
      step(2); check("t3_release", bgen_rstn, 1);
      wait_bclk(n); check("t3_first_tick", n, 20);
      wait_bclk(n); check("t3_period", n, 21);
      check("t3_ok", baud_ok, 1);
      step(1); rd_reg(2'd3, v); check("t3_status", v, 8'h51);

      // Early tick, overrun and recovery at Q = 20
      wait_bclk(n); step(1);
      gen_manual = 1'b1;
      man_tick(19); check("t4_early_ok", baud_ok, 0);
      man_tick(20); check("t4_recover_ok", baud_ok, 1);
      rd_reg(2'd3, v); check("t4_status_err", v, 8'h55);
      step(20); check("t4_edge_ok", baud_ok, 1);
      step(1);  check("t4_overrun_ok", baud_ok, 0);
      man_tick(0); check("t4_late_ok", baud_ok, 0);
      man_tick(20); check("t4_recover2_ok", baud_ok, 1);
      gen_manual = 1'b0;
      rd_reg(2'd3, v); check("t4_sticky", v, 8'h55);
      wr_reg(2'd3, 8'h04);
      rd_reg(2'd3, v); check("t4_clear", v, 8'h51);

      // Two commits during WAIT: second value applied in one reload
      line_busy = 1'b1;
      wr_reg(2'd0, 8'h1A); wr_reg(2'd2, 8'h03);
      wr_reg(2'd0, 8'h38); wr_reg(2'd2, 8'h03);
      step(3); check("t5_wait_div", dlh_dll, 16'h0104);
      line_busy = 1'b0;
      falls = 0; lows = 0; prev = bgen_rstn;
      for (int i = 0; i < 12 && !(falls > 0 && bgen_rstn); i++) begin
         step(1);
         if (prev && !bgen_rstn) falls++;
         if (!bgen_rstn) lows++;
         prev = bgen_rstn;
      end
      check("t5_falls", falls, 1); check("t5_lows", lows, 2);
      check("t5_div", dlh_dll, 16'h0138);
      wait_bclk(n); check("t5_first_tick", n, 24);
      step(1); check("t5_ok", baud_ok, 1);

      // Reset during APPLY
      rd_reg(2'd0, v); check("t6_dll", v, 8'h38);
      wr_reg(2'd2, 8'h03); step(1);
      check("t6_apply_rstn", bgen_rstn, 0);
      rst = 1'b1; step(1); rst = 1'b0;
      check("t6_div", dlh_dll, 16'h00A0); check("t6_mode", mode_osl, 0);
      check("t6_rstn", bgen_rstn, 0); check("t6_ok", baud_ok, 0);
      check("t6_rdata", rdata, 0);
      rd_reg(2'd3, v); check("t6_status", v, 8'h00);
      rd_reg(2'd0, v); check("t6_shadow", v, 8'hA0);
      step(20); check("t6_idle_rstn", bgen_rstn, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
